data_mem: RTL and testbench



---
 rtl/data_mem_pkg.sv | 16 +
 rtl/data_mem.sv | 35 +++
 tb/tb_data_mem.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// Shared sizing and memory map for the decoder data memory.
// Message image and decoded output regions live here so all users agree.
package data_mem_pkg;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 2 ** AW;

    localparam int MSG_IN_BASE  = 64;
    localparam int MSG_OUT_BASE = 0;
    localparam int REGION_LEN   = 64;

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] word_t;

endpackage

// File: rtl/data_mem.sv
// 256x8 data memory: synchronous write with sync clear, combinational read.
// The array `core` is accessed hierarchically by the decoder top and benches.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DW = data_mem_pkg::DW,
    parameter int AW = data_mem_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_en,
    input  logic [AW-1:0] raddr,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out
);

    localparam int NWORDS = 2 ** AW;

    logic [DW-1:0] core [0:NWORDS-1];

    // Plain always keeps hierarchical backdoor writes to core legal.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NWORDS; i++) begin
                core[i] <= '0;
            end
        end else if (write_en) begin
            core[waddr] <= data_in;
        end
    end

    assign data_out = core[raddr];

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem using a read-back scoreboard.
// Expected words are queued as stimulus is driven and compared on readout.
module tb_data_mem;
    import data_mem_pkg::*;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        string         name;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          write_en;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;

    int checks;
    int failures;

    exp_t          sb[$];
    logic [DW-1:0] model [0:DEPTH-1];

    data_mem #(.DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .write_en(write_en),
        .raddr   (raddr),
        .waddr   (waddr),
        .data_in (data_in),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        write_en = 1'b1;
        waddr    = a;
        data_in  = d;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        model[a] = d;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        exp_t e;
        do_write(8'd3, 8'hA5);
        sb.push_back('{8'd3, 8'hA5, "pre_reset_a3"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            raddr = e.addr;
            #1;
            checks++;
            if (data_out !== e.data) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, data_out, e.data);
            end
        end
        do_reset(1);
        sb.push_back('{8'd0,   8'h00, "reset_a0"});
        sb.push_back('{8'd3,   8'h00, "reset_a3"});
        sb.push_back('{8'd255, 8'h00, "reset_a255"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            raddr = e.addr;
            #1;
            checks++;
            if (data_out !== e.data) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, data_out, e.data);
            end
        end
    endtask

    task automatic test_basic();
        exp_t e;
        do_write(8'd64, 8'h5F);
        sb.push_back('{8'd64, 8'h5F, "basic_a64"});
        do_write(8'd127, 8'h1F);
        sb.push_back('{8'd127, 8'h1F, "basic_a127"});
        sb.push_back('{8'd65, model[65], "basic_a65_untouched"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            raddr = e.addr;
            #1;
            checks++;
            if (data_out !== e.data) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, data_out, e.data);
            end
        end
    endtask

    task automatic test_write_disable();
        exp_t e;
        @(negedge clk);
        write_en = 1'b0;
        waddr    = 8'd10;
        data_in  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back('{8'd10, model[10], "wdis_a10"});
        sb.push_back('{8'd64, model[64], "wdis_a64"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            raddr = e.addr;
            #1;
            checks++;
            if (data_out !== e.data) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, data_out, e.data);
            end
        end
    endtask

    task automatic test_read_during_write();
        do_write(8'd20, 8'h11);
        @(negedge clk);
        raddr    = 8'd20;
        waddr    = 8'd20;
        data_in  = 8'h22;
        write_en = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h11) begin
            failures++;
            $display("FAIL rdw_before: got %h expected %h", data_out, 8'h11);
        end
        @(posedge clk);
        #1;
        write_en = 1'b0;
        model[20] = 8'h22;
        checks++;
        if (data_out !== 8'h22) begin
            failures++;
            $display("FAIL rdw_after: got %h expected %h", data_out, 8'h22);
        end
    endtask

    task automatic test_collision();
        exp_t e;
        do_write(8'd255, 8'h33);
        do_write(8'd200, 8'h44);
        @(negedge clk);
        rst      = 1'b1;
        write_en = 1'b1;
        waddr    = 8'd255;
        data_in  = 8'h77;
        raddr    = 8'd255;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (data_out !== 8'h00) begin
                failures++;
                $display("FAIL coll_hold_%0d: got %h expected %h", c, data_out, 8'h00);
            end
        end
        rst      = 1'b0;
        write_en = 1'b0;
        model_clear();
        sb.push_back('{8'd200, 8'h00, "coll_prior_lost"});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            raddr = e.addr;
            #1;
            checks++;
            if (data_out !== e.data) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, data_out, e.data);
            end
        end
        do_write(8'd255, 8'h78);
        raddr = 8'd255;
        #1;
        checks++;
        if (data_out !== 8'h78) begin
            failures++;
            $display("FAIL coll_resume: got %h expected %h", data_out, 8'h78);
        end
    endtask

    task automatic test_backdoor();
        @(negedge clk);
        raddr = 8'd0;
        dut.core[0] = 8'h41;
        #1;
        checks++;
        if (data_out !== 8'h41) begin
            failures++;
            $display("FAIL backdoor_set: got %h expected %h", data_out, 8'h41);
        end
        do_write(8'd0, 8'h42);
        #1;
        checks++;
        if (data_out !== 8'h42) begin
            failures++;
            $display("FAIL backdoor_rtl_write: got %h expected %h", data_out, 8'h42);
        end
    endtask

    task automatic test_back_to_back();
        exp_t          e;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        do_reset(2);
        @(negedge clk);
        write_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            a = AW'($urandom_range(0, DEPTH - 1));
            d = DW'($urandom);
            waddr   = a;
            data_in = d;
            @(posedge clk);
            model[a] = d;
            @(negedge clk);
        end
        write_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back('{AW'(i), model[i], "b2b"});
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            raddr = e.addr;
            #1;
            checks++;
            if (data_out !== e.data) begin
                failures++;
                $display("FAIL %s a=%0d: got %h expected %h", e.name, e.addr, data_out, e.data);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        write_en = 1'b0;
        raddr    = '0;
        waddr    = '0;
        data_in  = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_write_disable();
        test_read_during_write();
        test_collision();
        test_backdoor();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
